// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and scan-code-set-2 decoder producing one-cycle key pulses.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity weight is even.
module ps2_keyboard #(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic                    left,
    output logic                    right,
    output logic                    backspace,
    output logic [SYMBOL_WIDTH-1:0] symbol
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              ps2_clk_s1_reg, ps2_clk_s2_reg, ps2_clk_prev_reg;
    logic              ps2_data_s1_reg, ps2_data_s2_reg;
    logic [9:0]        frame_reg;
    logic [3:0]        bit_cnt_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic [7:0]        byte_reg;
    logic              byte_valid_reg;
    logic              ext_reg, brk_reg, shift_reg;

    logic       ps2_fall;
    logic       parity_ok;
    logic       frame_ok;
    logic [7:0] letter_char, plain_char, shifted_char, char_next;

    assign ps2_fall = ps2_clk_prev_reg & ~ps2_clk_s2_reg;

    // frame_reg holds start/data/parity once ten bits are in; the stop bit is the live sample.
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^frame_reg[9:1];
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = ~frame_reg[0] & ps2_data_s2_reg & parity_ok;

    always_comb begin
        letter_char = 8'h00;
        case (byte_reg)
            8'h1C: letter_char = 8'h61; 8'h32: letter_char = 8'h62; 8'h21: letter_char = 8'h63;
            8'h23: letter_char = 8'h64; 8'h24: letter_char = 8'h65; 8'h2B: letter_char = 8'h66;
            8'h34: letter_char = 8'h67; 8'h33: letter_char = 8'h68; 8'h43: letter_char = 8'h69;
            8'h3B: letter_char = 8'h6A; 8'h42: letter_char = 8'h6B; 8'h4B: letter_char = 8'h6C;
            8'h3A: letter_char = 8'h6D; 8'h31: letter_char = 8'h6E; 8'h44: letter_char = 8'h6F;
            8'h4D: letter_char = 8'h70; 8'h15: letter_char = 8'h71; 8'h2D: letter_char = 8'h72;
            8'h1B: letter_char = 8'h73; 8'h2C: letter_char = 8'h74; 8'h3C: letter_char = 8'h75;
            8'h2A: letter_char = 8'h76; 8'h1D: letter_char = 8'h77; 8'h22: letter_char = 8'h78;
            8'h35: letter_char = 8'h79; 8'h1A: letter_char = 8'h7A;
            default: letter_char = 8'h00;
        endcase
    end

    always_comb begin
        plain_char = 8'h00;
        case (byte_reg)
            8'h45: plain_char = 8'h30; 8'h16: plain_char = 8'h31; 8'h1E: plain_char = 8'h32;
            8'h26: plain_char = 8'h33; 8'h25: plain_char = 8'h34; 8'h2E: plain_char = 8'h35;
            8'h36: plain_char = 8'h36; 8'h3D: plain_char = 8'h37; 8'h3E: plain_char = 8'h38;
            8'h46: plain_char = 8'h39; 8'h4E: plain_char = 8'h2D; 8'h55: plain_char = 8'h3D;
            8'h49: plain_char = 8'h2E; 8'h4A: plain_char = 8'h2F; 8'h29: plain_char = 8'h20;
            default: plain_char = 8'h00;
        endcase
    end

    always_comb begin
        shifted_char = 8'h00;
        case (byte_reg)
            8'h55: shifted_char = 8'h2B; 8'h3E: shifted_char = 8'h2A; 8'h46: shifted_char = 8'h28;
            8'h45: shifted_char = 8'h29; 8'h36: shifted_char = 8'h5E;
            default: shifted_char = 8'h00;
        endcase
    end

    // Letter codes never overlap digit/punctuation codes, so OR-ing the tables is safe.
    assign char_next = letter_char | (shift_reg ? shifted_char : plain_char);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_s1_reg   <= 1'b1;
            ps2_clk_s2_reg   <= 1'b1;
            ps2_clk_prev_reg <= 1'b1;
            ps2_data_s1_reg  <= 1'b1;
            ps2_data_s2_reg  <= 1'b1;
            frame_reg        <= '0;
            bit_cnt_reg      <= '0;
            idle_cnt_reg     <= '0;
            byte_reg         <= '0;
            byte_valid_reg   <= 1'b0;
            ext_reg          <= 1'b0;
            brk_reg          <= 1'b0;
            shift_reg        <= 1'b0;
            left             <= 1'b0;
            right            <= 1'b0;
            backspace        <= 1'b0;
            symbol           <= '0;
        end else begin
            ps2_clk_s1_reg   <= ps2_clk;
            ps2_clk_s2_reg   <= ps2_clk_s1_reg;
            ps2_clk_prev_reg <= ps2_clk_s2_reg;
            ps2_data_s1_reg  <= ps2_data;
            ps2_data_s2_reg  <= ps2_data_s1_reg;
            byte_valid_reg   <= 1'b0;
            left             <= 1'b0;
            right            <= 1'b0;
            backspace        <= 1'b0;
            symbol           <= '0;

            if (ps2_fall) begin
                idle_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= '0;
                    if (frame_ok) begin
                        byte_reg       <= frame_reg[8:1];
                        byte_valid_reg <= 1'b1;
                    end
                end else begin
                    frame_reg   <= {ps2_data_s2_reg, frame_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES)) begin
                if (bit_cnt_reg != 4'd0) begin
                    bit_cnt_reg <= '0;
                    frame_reg   <= '0;
                end
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (byte_valid_reg) begin
                if (byte_reg == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else if (byte_reg == 8'hF0) begin
                    brk_reg <= 1'b1;
                end else begin
                    ext_reg <= 1'b0;
                    brk_reg <= 1'b0;
                    if (byte_reg == 8'h12 || byte_reg == 8'h59)
                        shift_reg <= ~brk_reg;
                    if (!brk_reg) begin
                        if (ext_reg) begin
                            left  <= (byte_reg == 8'h6B);
                            right <= (byte_reg == 8'h74);
                        end else if (byte_reg == 8'h66) begin
                            backspace <= 1'b1;
                        end else begin
                            symbol <= SYMBOL_WIDTH'(char_next);
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed scenarios plus random frames against a table-driven key model.
module tb_ps2_keyboard;
    localparam int TO       = 300;
    localparam int HALF     = 20;
    localparam int EV_LEFT  = 1000;
    localparam int EV_RIGHT = 1001;
    localparam int EV_BKSP  = 1002;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left, right, backspace;
    logic [6:0] symbol;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int obs_q[$];
    int obs_t[$];
    int prev_active = 0;

    int  unsh[int];
    int  sh[int];
    bit  m_ext, m_brk, m_shift;

    ps2_keyboard #(.SYMBOL_WIDTH(7), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .left(left), .right(right), .backspace(backspace), .symbol(symbol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every pulse and checks exclusivity / one-cycle width.
    always @(negedge clk) begin
        int n;
        n = int'(left) + int'(right) + int'(backspace) + int'(symbol != 7'd0);
        if (n > 0) begin
            checks++;
            assert (n == 1) else begin
                errors++; $error("FAIL onehot observed=%0d expected=1", n);
            end
            checks++;
            assert (prev_active == 0) else begin
                errors++; $error("FAIL pulse_width observed=2+ cycles expected=1");
            end
            if (left)           obs_q.push_back(EV_LEFT);
            else if (right)     obs_q.push_back(EV_RIGHT);
            else if (backspace) obs_q.push_back(EV_BKSP);
            else                obs_q.push_back(int'(symbol));
            obs_t.push_back(cyc);
        end
        prev_active = (n > 0) ? 1 : 0;
    end

    function automatic void build_tables();
        logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) begin
            unsh[int'(lc[i])] = 97 + i;
            sh[int'(lc[i])]   = 97 + i;
        end
        for (int i = 0; i < 10; i++) unsh[int'(dc[i])] = 48 + i;
        unsh['h4E] = 'h2D; unsh['h55] = 'h3D; unsh['h49] = 'h2E; unsh['h4A] = 'h2F; unsh['h29] = 'h20;
        sh['h55] = 'h2B; sh['h3E] = 'h2A; sh['h46] = 'h28; sh['h45] = 'h29; sh['h36] = 'h5E;
    endfunction

    // Key model: returns the expected event for one accepted byte, or -1 for none.
    function automatic int model_byte(input logic [7:0] b);
        int r;
        int k;
        k = int'(b);
        if (k == 'hE0) begin m_ext = 1'b1; return -1; end
        if (k == 'hF0) begin m_brk = 1'b1; return -1; end
        r = -1;
        if (!m_brk) begin
            if (m_ext) begin
                if (k == 'h6B) r = EV_LEFT;
                if (k == 'h74) r = EV_RIGHT;
            end else if (k == 'h66) begin
                r = EV_BKSP;
            end else if (m_shift) begin
                if (sh.exists(k)) r = sh[k];
            end else begin
                if (unsh.exists(k)) r = unsh[k];
            end
        end
        if (k == 'h12 || k == 'h59) m_shift = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
        return r;
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic frame_txn(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        int  expv;
        int  got;
        bit  accepted;
`ifdef PS2_PARITY_CHECK_EN
        accepted = !bad_stop && !bad_par;
`else
        accepted = !bad_stop;
`endif
        expv = accepted ? model_byte(b) : -1;
        obs_q.delete();
        obs_t.delete();
        send_bits(make_frame(b, bad_par, bad_stop), 11);
        repeat (10) @(negedge clk);
        got = (obs_q.size() > 0) ? obs_q[0] : -1;
        checks++;
        assert (obs_q.size() == ((expv >= 0) ? 1 : 0)) else begin
            errors++; $error("FAIL %s_count observed=%0d expected=%0d", tag, obs_q.size(), (expv >= 0) ? 1 : 0);
        end
        checks++;
        assert (got === expv) else begin
            errors++; $error("FAIL %s_event observed=%0d expected=%0d", tag, got, expv);
        end
        if (expv >= 0 && obs_t.size() > 0) begin
            checks++;
            assert (obs_t[0] - fall_cyc === 4) else begin
                errors++; $error("FAIL %s_latency observed=%0d expected=4", tag, obs_t[0] - fall_cyc);
            end
        end
        $display("txn %-10s byte=%02h bad_par=%0d bad_stop=%0d expected=%0d observed=%0d",
                 tag, b, bad_par, bad_stop, expv, got);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        assert ({left, right, backspace, symbol} === 10'b0) else begin
            errors++; $error("FAIL %s observed=%b expected=0", tag, {left, right, backspace, symbol});
        end
    endtask

    initial begin
        logic [7:0] pool[16] = '{8'h1C, 8'h16, 8'h45, 8'h46, 8'h55, 8'h36, 8'h3E, 8'h29,
                                 8'hE0, 8'hF0, 8'h12, 8'h59, 8'h6B, 8'h74, 8'h66, 8'h4A};
        logic [7:0] b;
        build_tables();
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame_txn(8'h16, 0, 0, "digit1");
        frame_txn(8'hE0, 0, 0, "e0");
        frame_txn(8'h6B, 0, 0, "left");
        frame_txn(8'hE0, 0, 0, "e0");
        frame_txn(8'hF0, 0, 0, "f0");
        frame_txn(8'h6B, 0, 0, "left_brk");
        frame_txn(8'h6B, 0, 0, "flags_clr");
        frame_txn(8'h12, 0, 0, "shift_mk");
        frame_txn(8'h46, 0, 0, "lparen");
        frame_txn(8'hF0, 0, 0, "f0");
        frame_txn(8'h46, 0, 0, "brk46");
        frame_txn(8'hF0, 0, 0, "f0");
        frame_txn(8'h12, 0, 0, "shift_brk");
        frame_txn(8'h46, 0, 0, "digit9");
        frame_txn(8'h66, 0, 0, "bksp");
        frame_txn(8'h66, 0, 0, "bksp_rep");
        frame_txn(8'h1C, 1, 0, "bad_par");
        frame_txn(8'h1C, 0, 1, "bad_stop");

        // Partial frame followed by a long idle must be discarded.
        obs_q.delete();
        send_bits(make_frame(8'hFF, 0, 0), 5);
        repeat (TO + 50) @(negedge clk);
        frame_txn(8'h22, 0, 0, "timeout_x");

        // Reset in the middle of a frame, with shift held before it.
        frame_txn(8'h12, 0, 0, "shift_mk");
        send_bits(make_frame(8'h45, 0, 0), 7);
        rst = 1'b1;
        #1;
        check_idle_outputs("midframe_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0;
        repeat (5) @(negedge clk);
        frame_txn(8'h45, 0, 0, "post_rst");

        for (int i = 0; i < 60; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            frame_txn(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 7, giving the width of the symbol output.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, the idle clk cycles after which a partial frame is discarded.
REQ-003 SHALL have port clk  input  1  system clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port left  output  1  one-cycle pulse, left arrow pressed.
REQ-008 SHALL have port right  output  1  one-cycle pulse, right arrow pressed.
REQ-009 SHALL have port backspace  output  1  one-cycle pulse, backspace pressed.
REQ-010 SHALL have port symbol  output  SYMBOL_WIDTH  ASCII code for one cycle; 0 means no symbol.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, then detect falling edges of synchronized ps2_clk.
REQ-012 SHALL sample synchronized ps2_data on each falling edge into an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-013 SHALL accept a frame only if start=0 and stop=1, plus the parity condition in REQ-030/031; rejected frames are dropped silently.
REQ-014 SHALL register an accepted byte in cycle N (stop-bit edge) and drive the decoded output pulse in cycle N+1.
REQ-015 SHALL use an idle counter that resets on every falling edge; on reaching TIMEOUT_CYCLES with bit count nonzero, it SHALL clear bit count and shift register. Prefix and shift flags are kept.
REQ-016 SHALL track decoder flags: ext (set by E0), brk (set by F0), shift (set by make 12 or 59, cleared by break 12 or 59).
REQ-017 SHALL clear ext and brk after any byte that is not E0 or F0.
REQ-018 SHALL emit no output for any break sequence (brk set).
REQ-019 With ext set: make 6B SHALL pulse left; make 74 SHALL pulse right; all other extended codes are ignored.
REQ-020 With ext clear: make 66 SHALL pulse backspace.
REQ-021 Digit keys, unshifted, SHALL map to '0'-'9' (45,16,1E,26,25,2E,36,3D,3E,46); letter keys SHALL map to lowercase 'a'-'z' per scan code set 2, regardless of shift.
REQ-022 Unshifted: 4E->'-', 55->'=', 49->'.', 4A->'/', 29->' '. Shifted: 55->'+', 3E->'*', 46->'(', 45->')', 36->'^'. Other shifted digits SHALL be ignored.
REQ-023 Unmapped codes SHALL produce no output.
REQ-024 At most one of left, right, backspace, and nonzero symbol SHALL be active in any cycle; every output SHALL be exactly one cycle wide.
REQ-025 Typematic repeats (repeated make codes) SHALL each produce a pulse.
REQ-026 The block SHALL have no ready input; downstream must accept every pulse.

Reset
REQ-027 When rst is asserted, the block SHALL drive left, right, and backspace to 0 and symbol to 0 immediately (asynchronously).
REQ-028 Reset SHALL clear the synchronizers (to 1), shift register, bit count, idle counter, ext, brk, and shift.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL decode normally.

Configuration
REQ-030 With PS2_PARITY_CHECK_EN defined, a frame SHALL be accepted only if the 8 data bits plus the parity bit have odd weight.
REQ-031 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored; start and stop checks remain.

Verification
REQ-032 Frame 0x16 (parity 0): symbol=7'h31 ('1') for exactly one cycle, at N+1 after the stop edge.
REQ-033 Sequence E0 6B, then E0 F0 6B: left pulses once; no output on the break sequence; ext and brk end clear.
REQ-034 Sequence 12, 46, F0 46, F0 12, 46: '(' then '9'; sequence 66: backspace single pulse.
REQ-035 0x1C sent with wrong parity: no output with PS2_PARITY_CHECK_EN, symbol='a' without it.
REQ-036 Five bits of a frame, idle > TIMEOUT_CYCLES, then full frame 0x22: exactly one 'x', no spurious output.
REQ-037 rst asserted after bit 6 of a frame: all outputs 0; the next complete frame 0x45 yields ')' only if shift was held after reset, otherwise '0'.
